// File: rtl/dff_write_arbiter_rr_if.sv
// rtl/dff_write_arbiter_rr_if.sv - requester/arbiter bus; lock signal exists only with RR_WRITE_ARB_LOCK_EN
interface dff_write_arbiter_rr_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
`ifdef RR_WRITE_ARB_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic [IDW-1:0]         grant_id;
  logic                   valid;

`ifdef RR_WRITE_ARB_LOCK_EN
  modport master (output req, data, lock, input ack, q, grant_id, valid);
  modport slave  (input req, data, lock, output ack, q, grant_id, valid);
`else
  modport master (output req, data, input ack, q, grant_id, valid);
  modport slave  (input req, data, output ack, q, grant_id, valid);
`endif
endinterface

// File: rtl/dff_write_arbiter_rr.sv
// rtl/dff_write_arbiter_rr.sv - round-robin write arbiter for one shared register; optional grant lock via RR_WRITE_ARB_LOCK_EN
module dff_write_arbiter_rr #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  dff_write_arbiter_rr_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   ptr_next;
  logic             found;
  logic             xfer;
  logic [N_REQ-1:0] ack_c;
  logic [WIDTH-1:0] q_r;
  logic [IDW-1:0]   id_r;
  logic             valid_r;

`ifdef RR_WRITE_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t         state;
  logic [IDW-1:0] owner;
`endif

  function automatic int wrap_idx(input int i);
    return (i >= N_REQ) ? i - N_REQ : i;
  endfunction

  // First active requester scanning from ptr upward with wrap; data never enters this path
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[wrap_idx(int'(ptr) + k)]) begin
        found = 1'b1;
        win   = IDW'(wrap_idx(int'(ptr) + k));
      end
    end
  end

  // Grant: locked owner only, else the round-robin winner; nothing while reset is low
  always_comb begin
    ack_c = '0;
    sel   = win;
`ifdef RR_WRITE_ARB_LOCK_EN
    if (state == LOCKED) begin
      sel = owner;
      if (bus.req[owner]) ack_c[owner] = 1'b1;
    end else if (found) begin
      ack_c[win] = 1'b1;
    end
`else
    if (found) ack_c[win] = 1'b1;
`endif
    if (!async_rst_n) ack_c = '0;
  end

  assign xfer     = |ack_c;
  assign ptr_next = (sel == IDW'(N_REQ - 1)) ? '0 : sel + IDW'(1);

  // Shared register, last-writer id and pointer advance on every transfer
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      q_r     <= '0;
      id_r    <= '0;
      valid_r <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      q_r     <= bus.data[int'(sel)*WIDTH +: WIDTH];
      id_r    <= sel;
      valid_r <= 1'b1;
      ptr     <= ptr_next;
    end
  end

`ifdef RR_WRITE_ARB_LOCK_EN
  // Lock FSM: enter on a transfer with lock set, leave when owner drops req or writes unlocked
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= ARB;
      owner <= '0;
    end else begin
      case (state)
        ARB: begin
          if (xfer && bus.lock[sel]) begin
            state <= LOCKED;
            owner <= sel;
          end
        end
        LOCKED: begin
          if (!bus.req[owner] || !bus.lock[owner]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end
`endif

  assign bus.ack      = ack_c;
  assign bus.q        = q_r;
  assign bus.grant_id = id_r;
  assign bus.valid    = valid_r;
endmodule

// File: tb/tb_dff_write_arbiter_rr.sv
// tb/tb_dff_write_arbiter_rr.sv - scoreboard bench for dff_write_arbiter_rr (N_REQ=4, WIDTH=4)
module tb_dff_write_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dff_write_arbiter_rr_if #(.N_REQ(4), .WIDTH(4)) bus ();

  dff_write_arbiter_rr #(.N_REQ(4), .WIDTH(4)) dut (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (bus.slave)
  );

  typedef struct {
    logic [3:0] q;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [1:0] ptr_m;
  logic [3:0] q_m;
  logic [1:0] id_m;
  logic       valid_m;
  logic       locked_m;
  logic [1:0] owner_m;
  logic [3:0] lock_v;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ack(input logic [3:0] r);
    logic [3:0] a;
    a = '0;
`ifdef RR_WRITE_ARB_LOCK_EN
    if (locked_m) begin
      if (r[owner_m]) a[owner_m] = 1'b1;
      return a;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      if (a == 4'b0 && r[(int'(ptr_m) + k) % 4]) a[(int'(ptr_m) + k) % 4] = 1'b1;
    end
    return a;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    ptr_m    = '0;
    q_m      = '0;
    id_m     = '0;
    valid_m  = 1'b0;
    locked_m = 1'b0;
    owner_m  = '0;
    sb.delete();
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] d, input logic [3:0] lk,
                      input logic [3:0] spec_ack, input bit use_spec);
    logic [3:0] e;
    logic [1:0] w;
    exp_t       x;
    @(negedge clk);
    bus.req  = r;
    bus.data = d;
    lock_v   = lk;
`ifdef RR_WRITE_ARB_LOCK_EN
    bus.lock = lk;
`endif
    #1;
    e = model_ack(r);
    check("ack", 16'(bus.ack), 16'(e));
    if (use_spec) check("ack_spec", 16'(bus.ack), 16'(spec_ack));
    if (e != 4'b0) begin
      w    = onehot_idx(e);
      x.q  = d[w*4 +: 4];
      x.id = w;
      sb.push_back(x);
      q_m     = x.q;
      id_m    = w;
      valid_m = 1'b1;
      ptr_m   = w + 2'd1;
    end
`ifdef RR_WRITE_ARB_LOCK_EN
    if (locked_m) begin
      if (!r[owner_m] || !lock_v[owner_m]) locked_m = 1'b0;
    end else if (e != 4'b0 && lock_v[onehot_idx(e)]) begin
      locked_m = 1'b1;
      owner_m  = onehot_idx(e);
    end
`endif
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("q", 16'(bus.q), 16'(x.q));
      check("grant_id", 16'(bus.grant_id), 16'(x.id));
      check("valid", 16'(bus.valid), 16'd1);
    end else begin
      check("hold_q", 16'(bus.q), 16'(q_m));
      check("hold_id", 16'(bus.grant_id), 16'(id_m));
      check("hold_valid", 16'(bus.valid), 16'(valid_m));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_q", 16'(bus.q), 16'd0);
    check("rst_valid", 16'(bus.valid), 16'd0);
    check("rst_id", 16'(bus.grant_id), 16'd0);
    check("rst_ack", 16'(bus.ack), 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_ack_edge", 16'(bus.ack), 16'd0);
    check("rst_q_edge", 16'(bus.q), 16'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.data = '0;
    lock_v   = '0;
`ifdef RR_WRITE_ARB_LOCK_EN
    bus.lock = '0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_reset();

    step(4'b0000, 16'h0000, 4'b0, 4'b0000, 1'b1);

    step(4'b1111, 16'hDCBA, 4'b0, 4'b0001, 1'b1);
    step(4'b1111, 16'hDCBA, 4'b0, 4'b0010, 1'b1);
    step(4'b1111, 16'hDCBA, 4'b0, 4'b0100, 1'b1);
    step(4'b1111, 16'hDCBA, 4'b0, 4'b1000, 1'b1);
    step(4'b1111, 16'hDCBA, 4'b0, 4'b0001, 1'b1);
    check("rot_last_q", 16'(bus.q), 16'hA);

    step(4'b0100, 16'h0300, 4'b0, 4'b0100, 1'b1);
    step(4'b0101, 16'h0502, 4'b0, 4'b0001, 1'b1);
    step(4'b0101, 16'h0502, 4'b0, 4'b0100, 1'b1);
    step(4'b0101, 16'h0502, 4'b0, 4'b0001, 1'b1);

    step(4'b0100, 16'h0700, 4'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 16'h0000, 4'b0, 4'b0000, 1'b1);
      check("idle_q", 16'(bus.q), 16'h7);
      check("idle_id", 16'(bus.grant_id), 16'd2);
      check("idle_valid", 16'(bus.valid), 16'd1);
    end

`ifdef RR_WRITE_ARB_LOCK_EN
    step(4'b0011, 16'h0021, 4'b0001, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0001, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0001, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0000, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0000, 4'b0010, 1'b1);
`else
    step(4'b0011, 16'h0021, 4'b0001, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0001, 4'b0010, 1'b1);
    step(4'b0011, 16'h0021, 4'b0001, 4'b0001, 1'b1);
    step(4'b0011, 16'h0021, 4'b0000, 4'b0010, 1'b1);
    step(4'b0011, 16'h0021, 4'b0000, 4'b0001, 1'b1);
`endif

    step(4'b1111, 16'h9876, 4'b0, 4'b0, 1'b0);
    do_reset();
    step(4'b1111, 16'h4321, 4'b0, 4'b0001, 1'b1);

    step(4'b1000, 16'hE000, 4'b0, 4'b1000, 1'b1);
    step(4'b1000, 16'hE000, 4'b0, 4'b1000, 1'b1);
    step(4'b1000, 16'hF000, 4'b0, 4'b1000, 1'b1);

    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)), 4'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
